// File: rtl/lsu_thread.sv
// lsu_thread: per-thread load/store unit. It issues one memory access per
// REQUEST phase, waits for the memory to answer, and parks in DONE until the
// core reaches its UPDATE phase. An optional timeout aborts an access that is
// never acknowledged and flags the abort on lsu_error.
module lsu_thread #(
   parameter int ADDR_BITS      = 8,
   parameter int DATA_BITS      = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic [2:0]           core_state,
   input  logic                 decoded_mem_read_enable,
   input  logic                 decoded_mem_write_enable,
   input  logic [DATA_BITS-1:0] rs,
   input  logic [DATA_BITS-1:0] rt,
   output logic                 mem_read_valid,
   output logic [ADDR_BITS-1:0] mem_read_address,
   input  logic                 mem_read_ready,
   input  logic [DATA_BITS-1:0] mem_read_data,
   output logic                 mem_write_valid,
   output logic [ADDR_BITS-1:0] mem_write_address,
   output logic [DATA_BITS-1:0] mem_write_data,
   input  logic                 mem_write_ready,
   output logic [1:0]           lsu_state,
   output logic [DATA_BITS-1:0] lsu_out,
   output logic                 lsu_error
);

   localparam logic [2:0] CORE_REQUEST = 3'b011;
   localparam logic [2:0] CORE_UPDATE  = 3'b110;

   // A zero timeout still needs a one-bit counter so the logic stays legal.
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_IDLE       = 2'b00,
      S_REQUESTING = 2'b01,
      S_WAITING    = 2'b10,
      S_DONE       = 2'b11
   } state_t;

   state_t                 state_q;
   logic                   is_read_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [CNT_W-1:0]       cnt_d;
   logic                   rd_valid_q;
   logic                   wr_valid_q;
   logic [ADDR_BITS-1:0]   rd_addr_q;
   logic [ADDR_BITS-1:0]   wr_addr_q;
   logic [DATA_BITS-1:0]   wr_data_q;
   logic [DATA_BITS-1:0]   out_q;
   logic                   err_q;
   logic                   timeout_hit;
   logic                   ready_sel;
   logic                   unused_rs_hi;

   // Only the low address bits of rs are meaningful; the rest are discarded.
   assign unused_rs_hi = ^rs;

   // Saturating timeout increment, timeout detection and selected-channel ready.
   always_comb begin
      cnt_d       = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == TO_VAL);
      ready_sel   = is_read_q ? mem_read_ready : mem_write_ready;
   end

   // Access sequencer: issue, wait for ready or timeout, hold result until UPDATE.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         is_read_q  <= 1'b0;
         cnt_q      <= '0;
         rd_valid_q <= 1'b0;
         wr_valid_q <= 1'b0;
         rd_addr_q  <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         out_q      <= '0;
         err_q      <= 1'b0;
      end else if (enable) begin
         case (state_q)
            S_IDLE: begin
               if (core_state == CORE_REQUEST &&
                   (decoded_mem_read_enable || decoded_mem_write_enable)) begin
                  // A load wins when both enables are set; the store is dropped.
                  is_read_q <= decoded_mem_read_enable;
                  err_q     <= 1'b0;
                  state_q   <= S_REQUESTING;
               end
            end
            S_REQUESTING: begin
               if (is_read_q) begin
                  rd_addr_q  <= rs[ADDR_BITS-1:0];
                  rd_valid_q <= 1'b1;
               end else begin
                  wr_addr_q  <= rs[ADDR_BITS-1:0];
                  wr_data_q  <= rt;
                  wr_valid_q <= 1'b1;
               end
               cnt_q   <= '0;
               state_q <= S_WAITING;
            end
            S_WAITING: begin
               // Ready is checked first so an answer on the timeout edge completes normally.
               if (ready_sel) begin
                  rd_valid_q <= 1'b0;
                  wr_valid_q <= 1'b0;
                  if (is_read_q) begin
                     out_q <= mem_read_data;
                  end
                  state_q <= S_DONE;
               end else if (timeout_hit) begin
                  rd_valid_q <= 1'b0;
                  wr_valid_q <= 1'b0;
                  err_q      <= 1'b1;
                  if (is_read_q) begin
                     out_q <= '0;
                  end
                  state_q <= S_DONE;
               end else begin
                  cnt_q <= cnt_d;
               end
            end
            S_DONE: begin
               if (core_state == CORE_UPDATE) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_read_valid    = rd_valid_q;
   assign mem_read_address  = rd_addr_q;
   assign mem_write_valid   = wr_valid_q;
   assign mem_write_address = wr_addr_q;
   assign mem_write_data    = wr_data_q;
   assign lsu_state         = state_q;
   assign lsu_out           = out_q;
   assign lsu_error         = err_q;

endmodule

// File: tb/tb_lsu_thread.sv
// Bench for lsu_thread: directed and randomized load/store transactions with a
// queue-based scoreboard and an independent output monitor.
module tb_lsu_thread;

   localparam int T = 4;
   localparam logic [2:0] REQ = 3'b011;
   localparam logic [2:0] UPD = 3'b110;
   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_WAIT = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        enable = 1'b0;
   logic [2:0]  core_state = 3'b000;
   logic        rd_en = 1'b0;
   logic        wr_en = 1'b0;
   logic [15:0] rs = '0;
   logic [15:0] rt = '0;
   logic        mem_read_valid;
   logic [7:0]  mem_read_address;
   logic        mem_read_ready = 1'b0;
   logic [15:0] mem_read_data = '0;
   logic        mem_write_valid;
   logic [7:0]  mem_write_address;
   logic [15:0] mem_write_data;
   logic        mem_write_ready = 1'b0;
   logic [1:0]  lsu_state;
   logic [15:0] lsu_out;
   logic        lsu_error;

   lsu_thread #(.ADDR_BITS(8), .DATA_BITS(16), .TIMEOUT_CYCLES(T)) dut (
      .clk                      (clk),
      .reset                    (reset),
      .enable                   (enable),
      .core_state               (core_state),
      .decoded_mem_read_enable  (rd_en),
      .decoded_mem_write_enable (wr_en),
      .rs                       (rs),
      .rt                       (rt),
      .mem_read_valid           (mem_read_valid),
      .mem_read_address         (mem_read_address),
      .mem_read_ready           (mem_read_ready),
      .mem_read_data            (mem_read_data),
      .mem_write_valid          (mem_write_valid),
      .mem_write_address        (mem_write_address),
      .mem_write_data           (mem_write_data),
      .mem_write_ready          (mem_write_ready),
      .lsu_state                (lsu_state),
      .lsu_out                  (lsu_out),
      .lsu_error                (lsu_error)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          rd;
      logic [7:0]  addr;
      logic [15:0] wd;
      int          cyc;
      logic [15:0] out;
      bit          err;
   } exp_t;

   exp_t        sb[$];
   int          n_tests = 0;
   int          n_fail = 0;
   logic [15:0] model_out = '0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Monitor: observes the DUT just after each rising edge and retires one
   // scoreboard entry whenever the unit enters DONE.
   logic [1:0]  prev_st = 2'b00;
   bit          prev_v = 0;
   int          vcnt = 0;
   bit          viol = 0;
   bit          first = 1;
   bit          seen_rd = 0;
   bit          seen_wr = 0;
   logic [7:0]  a0 = '0;
   logic [15:0] d0 = '0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_st = ST_IDLE; prev_v = 0; vcnt = 0; viol = 0;
         first = 1; seen_rd = 0; seen_wr = 0;
      end else begin
         exp_t x;
         logic [7:0] a_now;
         #1;
         if (prev_v && enable) vcnt++;
         if (mem_read_valid && mem_write_valid) viol = 1;
         if ((mem_read_valid || mem_write_valid) && lsu_state != ST_WAIT) viol = 1;
         if (mem_read_valid || mem_write_valid) begin
            a_now = mem_read_valid ? mem_read_address : mem_write_address;
            if (first) begin
               first = 0;
               a0 = a_now;
               d0 = mem_write_data;
               seen_rd = mem_read_valid;
               seen_wr = mem_write_valid;
            end else if (a_now != a0 || (mem_write_valid && mem_write_data != d0)) begin
               viol = 1;
            end
         end
         if (lsu_state == ST_DONE && prev_st != ST_DONE) begin
            if (sb.size() == 0) begin
               chk("unexpected_done", 1, 0);
            end else begin
               x = sb.pop_front();
               chk("read_valid_seen", seen_rd, x.rd);
               chk("write_valid_seen", seen_wr, !x.rd);
               chk("address", a0, x.addr);
               if (!x.rd) chk("write_data", d0, x.wd);
               chk("valid_edges", vcnt, x.cyc);
               chk("lsu_out", lsu_out, x.out);
               chk("lsu_error", lsu_error, x.err);
               chk("valid_protocol", viol, 0);
            end
            vcnt = 0; first = 1; seen_rd = 0; seen_wr = 0; viol = 0;
         end
         if (prev_st == ST_DONE && lsu_state != ST_DONE) chk("done_exit", lsu_state, ST_IDLE);
         prev_st = lsu_state;
         prev_v = mem_read_valid || mem_write_valid;
      end
   end

   // One access. mode: 0 store, 1 load, 2 both enables. dly: cycles after
   // valid rises until ready (negative = never). stall: enable low for three
   // cycles right before the final waiting edge.
   task automatic txn(input int mode, input logic [15:0] rs_v, input logic [15:0] rt_v,
                      input int dly, input logic [15:0] rdat, input bit stall);
      exp_t x;
      bit   abort;
      int   e;
      abort = (dly < 0) || (dly > T);
      e = abort ? T + 1 : dly + 1;
      x.rd = (mode != 0);
      x.addr = rs_v[7:0];
      x.wd = rt_v;
      x.cyc = e;
      x.err = abort;
      x.out = x.rd ? (abort ? 16'h0 : rdat) : model_out;
      model_out = x.out;
      sb.push_back(x);

      @(negedge clk);
      enable = 1; core_state = REQ;
      rd_en = (mode != 0); wr_en = (mode != 1);
      rs = rs_v; rt = rt_v; mem_read_data = rdat;
      @(negedge clk);
      core_state = 3'b000;
      @(negedge clk);
      rs = 16'($urandom); rt = 16'($urandom);
      for (int k = 1; k <= e; k++) begin
         mem_read_ready  = x.rd && (k == dly + 1);
         mem_write_ready = !x.rd && (k == dly + 1);
         if (stall && k == e) begin
            enable = 0;
            repeat (3) @(negedge clk);
            enable = 1;
         end
         @(negedge clk);
      end
      mem_read_data = 16'($urandom);
      @(negedge clk);
      mem_read_ready = 0; mem_write_ready = 0;
      core_state = UPD;
      @(negedge clk);
      core_state = 3'b000; rd_en = 0; wr_en = 0;
      chk("scoreboard_drained", sb.size(), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
      n_fail++;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_state", lsu_state, ST_IDLE);
      chk("rst_rvalid", mem_read_valid, 0);
      chk("rst_wvalid", mem_write_valid, 0);
      chk("rst_raddr", mem_read_address, 0);
      chk("rst_waddr", mem_write_address, 0);
      chk("rst_wdata", mem_write_data, 0);
      chk("rst_out", lsu_out, 0);
      chk("rst_err", lsu_error, 0);
      reset = 1;

      // IDLE must hold without a qualifying edge
      @(negedge clk); enable = 1; core_state = REQ; rd_en = 0; wr_en = 0;
      @(negedge clk); chk("idle_no_enables", lsu_state, ST_IDLE);
      enable = 0; rd_en = 1;
      @(negedge clk); chk("idle_disabled", lsu_state, ST_IDLE);
      enable = 1; core_state = UPD;
      @(negedge clk); chk("idle_wrong_phase", lsu_state, ST_IDLE);
      core_state = 3'b000; rd_en = 0;

      // Directed transactions
      txn(1, 16'h0012, 16'h5555, 3, 16'hBEEF, 0);   // load, ready after 3 cycles
      txn(0, 16'h01A5, 16'h1234, 0, 16'h0000, 0);   // store, ready immediately
      txn(1, 16'h0040, 16'h0000, -1, 16'h7777, 0);  // load timeout
      txn(1, 16'h0041, 16'h0000, 2, 16'hCAFE, 0);   // error clears on next access
      txn(0, 16'h0042, 16'hAAAA, -1, 16'h0000, 0);  // store timeout keeps lsu_out
      txn(2, 16'h0007, 16'h9999, 1, 16'h4321, 0);   // both enables: load wins
      txn(1, 16'h0033, 16'h0000, T, 16'h0BAD, 0);   // ready on the timeout edge
      txn(1, 16'h0055, 16'h0000, 1, 16'hF00D, 1);   // stall with ready high

      // Reset in the middle of WAITING
      @(negedge clk); core_state = REQ; rd_en = 1; rs = 16'h0033;
      @(negedge clk); core_state = 3'b000;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 0;
      #1;
      chk("midrst_rvalid", mem_read_valid, 0);
      chk("midrst_state", lsu_state, ST_IDLE);
      chk("midrst_out", lsu_out, 0);
      chk("midrst_raddr", mem_read_address, 0);
      model_out = '0;
      mem_read_ready = 1;
      @(negedge clk); reset = 1;
      repeat (3) @(negedge clk);
      chk("postrst_state", lsu_state, ST_IDLE);
      chk("postrst_rvalid", mem_read_valid, 0);
      chk("postrst_out", lsu_out, 0);
      mem_read_ready = 0; rd_en = 0;

      // Randomized transactions
      for (int i = 0; i < 40; i++) begin
         int r;
         r = int'($urandom_range(0, 8));
         txn(int'($urandom_range(0, 2)), 16'($urandom), 16'($urandom),
             (r == 8) ? -1 : r, 16'($urandom), ($urandom_range(0, 4) == 0));
      end

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_thread.md
LSU_THREAD -- requirements
Module: lsu_thread

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 8, memory address width.
REQ-002 SHALL have parameter DATA_BITS, default 16, data width, matching the thread register file.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum WAITING cycles before abort; 0 disables the timeout.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 enable  input  1  thread active; when low, all state and outputs hold.
REQ-007 core_state  input  3  core phase; REQUEST=3'b011, UPDATE=3'b110.
REQ-008 decoded_mem_read_enable  input  1  current instruction is a load.
REQ-009 decoded_mem_write_enable  input  1  current instruction is a store.
REQ-010 rs  input  DATA_BITS  address operand from the register file.
REQ-011 rt  input  DATA_BITS  store data operand from the register file.
REQ-012 mem_read_valid / mem_read_address / mem_read_ready / mem_read_data  output 1 / output ADDR_BITS / input 1 / input DATA_BITS  read channel.
REQ-013 mem_write_valid / mem_write_address / mem_write_data / mem_write_ready  output 1 / output ADDR_BITS / output DATA_BITS / input 1  write channel.
REQ-014 lsu_state  output  2  IDLE=00, REQUESTING=01, WAITING=10, DONE=11.
REQ-015 lsu_out  output  DATA_BITS  last loaded value; feeds the register-file MEMORY write path.
REQ-016 lsu_error  output  1  last access aborted by timeout.

Function
REQ-017 IDLE->REQUESTING SHALL occur on the edge where enable=1, core_state=REQUEST and either mem enable is 1; otherwise IDLE SHALL hold.
REQ-018 If both read and write enables are 1, the access SHALL be a read; the write SHALL be dropped.
REQ-019 On the edge leaving IDLE, lsu_error SHALL clear to 0.
REQ-020 In REQUESTING, the next edge SHALL register address=rs[ADDR_BITS-1:0] (upper bits discarded); write data=rt; assert the selected valid; clear the timeout counter; and enter WAITING.
REQ-021 Ready seen in IDLE, REQUESTING or DONE SHALL be ignored.
REQ-022 In WAITING with ready=1 on the selected channel, the edge SHALL deassert valid and enter DONE; a read SHALL also capture mem_read_data into lsu_out.
REQ-023 Valid SHALL stay high and address/data stable each WAITING cycle without ready; total valid-to-DONE latency is N+1 edges for ready first sampled N cycles after valid rises.
REQ-024 Each WAITING cycle without ready SHALL increment the timeout counter (width clog2(TIMEOUT_CYCLES+1), saturating).
REQ-025 When the counter equals TIMEOUT_CYCLES (nonzero) without ready, the next edge SHALL deassert valid, set lsu_error=1, set lsu_out=0 for a read, and enter DONE.
REQ-026 Ready arriving on the same edge as timeout SHALL win: normal completion, lsu_error=0.
REQ-027 A write SHALL never modify lsu_out.
REQ-028 DONE SHALL hold until an edge with core_state=UPDATE, then go to IDLE.
REQ-029 lsu_out and lsu_error SHALL hold through IDLE until the next completion or abort.
REQ-030 At most one valid SHALL be high at any time, and only in WAITING.
REQ-031 enable=0 mid-access SHALL freeze state, the counter and valid.

Reset
REQ-032 reset=0 SHALL immediately and asynchronously force lsu_state=IDLE, both valids=0, all addresses/data=0, lsu_out=0, lsu_error=0, counter=0, including mid-access.
REQ-033 After reset deasserts, the first transition SHALL require a fresh REQUEST-state edge.

Verification
REQ-034 Load: rs=0x0012, REQUEST, ready 3 cycles after valid, data=0xBEEF -> read_address=0x12, valid high 4 cycles, lsu_out=0xBEEF, DONE until UPDATE, then IDLE.
REQ-035 Store: rs=0x01A5, rt=0x1234, ready on first WAITING cycle -> write_address=0xA5, write_data=0x1234, valid high 1 cycle, lsu_out unchanged.
REQ-036 Timeout: TIMEOUT_CYCLES=4, ready never -> valid drops after 5 WAITING cycles, lsu_error=1, lsu_out=0, DONE.
REQ-037 Both enables=1, rs=0x0007 -> only mem_read_valid asserts, address 0x07, write channel idle.
REQ-038 reset low during WAITING -> valid low same cycle, lsu_state=IDLE, no completion after release.
REQ-039 enable low 3 cycles in WAITING with ready=1 -> no completion; completes on first enabled edge.
